// File: rtl/alu_req_dispatcher_pkg.sv
// Shared definitions for the ALU request dispatcher: ALU control codes,
// dispatcher state encodings and datapath widths.
package alu_req_dispatcher_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CTL_W   = 3;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [CTL_W-1:0] ALU_AND     = 3'b000;
  localparam logic [CTL_W-1:0] ALU_OR      = 3'b001;
  localparam logic [CTL_W-1:0] ALU_ADD     = 3'b010;
  localparam logic [CTL_W-1:0] ALU_ILLEGAL = 3'b011;
  localparam logic [CTL_W-1:0] ALU_SLL     = 3'b100;
  localparam logic [CTL_W-1:0] ALU_SRL     = 3'b101;
  localparam logic [CTL_W-1:0] ALU_SUB     = 3'b110;
  localparam logic [CTL_W-1:0] ALU_SLT     = 3'b111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  function automatic logic is_illegal(input logic [CTL_W-1:0] ctl);
    return ctl == ALU_ILLEGAL;
  endfunction

endpackage

// File: rtl/alu_req_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr,
// wrapping modulo N. The pointer register is owned by the caller.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr) + i) % N);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_req_dispatcher.sv
// Multiplexes ALU requests from NCORES cores onto one shared ALU and returns
// a tagged response to the issuing core.
module alu_req_dispatcher
  import alu_req_dispatcher_pkg::*;
#(
  parameter int unsigned NCORES = 4,
  parameter int unsigned IDW    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NCORES-1:0]           req_valid,
  output logic [NCORES-1:0]           req_ready,
  input  logic [CTL_W*NCORES-1:0]     req_ctl,
  input  logic [DATA_W*NCORES-1:0]    req_a,
  input  logic [DATA_W*NCORES-1:0]    req_b,
  input  logic [SHAMT_W*NCORES-1:0]   req_shamt,
  output logic [CTL_W-1:0]            alu_ctl,
  output logic [DATA_W-1:0]           alu_a,
  output logic [DATA_W-1:0]           alu_b,
  output logic [SHAMT_W-1:0]          alu_shamt,
  input  logic [DATA_W-1:0]           alu_result,
  input  logic                        alu_zero,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [IDW-1:0]              rsp_id,
  output logic [DATA_W-1:0]           rsp_result,
  output logic                        rsp_zero,
  output logic                        rsp_err
);

  logic [1:0]         state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [CTL_W-1:0]   alu_ctl_q, alu_ctl_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d;
  logic [DATA_W-1:0]  alu_b_q, alu_b_d;
  logic [SHAMT_W-1:0] alu_shamt_q, alu_shamt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]  rsp_result_q, rsp_result_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               rsp_err_q, rsp_err_d;

  logic               arb_en;
  logic [NCORES-1:0]  gnt;
  logic [IDW-1:0]     gnt_idx;
  logic               accept;
  logic [CTL_W-1:0]   sel_ctl;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic [SHAMT_W-1:0] sel_shamt;

  // Grants are offered when idle, or when the current response retires this cycle.
  assign arb_en = reset && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));

  rr_arbiter #(
    .N  (NCORES),
    .PW (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;

  always_comb begin
    sel_ctl   = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_shamt = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      if (gnt[i]) begin
        sel_ctl   = req_ctl[CTL_W*i +: CTL_W];
        sel_a     = req_a[DATA_W*i +: DATA_W];
        sel_b     = req_b[DATA_W*i +: DATA_W];
        sel_shamt = req_shamt[SHAMT_W*i +: SHAMT_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    alu_ctl_d    = alu_ctl_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_shamt_d  = alu_shamt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      ST_IDLE: ;
      ST_ISSUE: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_err_d    = 1'b0;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Accept overrides the per-state result; only reachable from IDLE or retiring RESP.
    if (accept) begin
      ptr_d    = (gnt_idx == IDW'(NCORES - 1)) ? '0 : gnt_idx + IDW'(1);
      rsp_id_d = gnt_idx;
      if (is_illegal(sel_ctl)) begin
        rsp_result_d = '0;
        rsp_zero_d   = 1'b0;
        rsp_err_d    = 1'b1;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end else begin
        alu_ctl_d   = sel_ctl;
        alu_a_d     = sel_a;
        alu_b_d     = sel_b;
        alu_shamt_d = sel_shamt;
        rsp_valid_d = 1'b0;
        state_d     = ST_ISSUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      alu_ctl_q    <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_shamt_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      alu_ctl_q    <= alu_ctl_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_shamt_q  <= alu_shamt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_ctl    = alu_ctl_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_shamt  = alu_shamt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_req_dispatcher.sv
// Directed bench for alu_req_dispatcher with a behavioural ALU on the alu_* port.
module tb_alu_req_dispatcher;
  import alu_req_dispatcher_pkg::*;

  localparam int unsigned NCORES = 4;
  localparam int unsigned IDW    = 2;

  logic                      clk;
  logic                      reset;
  logic [NCORES-1:0]         req_valid;
  logic [NCORES-1:0]         req_ready;
  logic [CTL_W*NCORES-1:0]   req_ctl;
  logic [DATA_W*NCORES-1:0]  req_a;
  logic [DATA_W*NCORES-1:0]  req_b;
  logic [SHAMT_W*NCORES-1:0] req_shamt;
  logic [CTL_W-1:0]          alu_ctl;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [SHAMT_W-1:0]        alu_shamt;
  logic [DATA_W-1:0]         alu_result;
  logic                      alu_zero;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [IDW-1:0]            rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_zero;
  logic                      rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  alu_req_dispatcher #(.NCORES(NCORES), .IDW(IDW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ctl    (req_ctl),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_shamt  (req_shamt),
    .alu_ctl    (alu_ctl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_shamt  (alu_shamt),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shared ALU
  always_comb begin
    case (alu_ctl)
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLL: alu_result = alu_b << alu_shamt;
      ALU_SRL: alu_result = alu_b >> alu_shamt;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int core, input logic [2:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] shamt);
    req_valid[core]           = 1'b1;
    req_ctl[3*core +: 3]      = ctl;
    req_a[32*core +: 32]      = a;
    req_b[32*core +: 32]      = b;
    req_shamt[5*core +: 5]    = shamt;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; req_valid = '1; req_ctl = '0; req_a = '0; req_b = '0;
    req_shamt = '0; rsp_ready = 1'b1;

    // Reset state, with all requests asserted
    step(); step();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_ctl", 32'(alu_ctl), 32'h0);
    check("rst_rsp", {rsp_result[28:0], rsp_zero, rsp_err, 1'b0} | 32'(rsp_id), 32'h0);
    req_valid = '0;
    reset = 1'b1;
    #1;

    // 1: single op
    set_req(1, ALU_ADD, 32'd5, 32'd7, 5'd0);
    #1;
    check("t1_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    check("t1_alu_a", alu_a, 32'd5);
    check("t1_alu_b", alu_b, 32'd7);
    check("t1_issue_valid", 32'(rsp_valid), 32'h0);
    step();
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1_result", rsp_result, 32'd12);
    check("t1_zero", 32'(rsp_zero), 32'h0);
    check("t1_id", 32'(rsp_id), 32'h1);
    check("t1_err", 32'(rsp_err), 32'h0);
    step();
    check("t1_retire", 32'(rsp_valid), 32'h0);

    // 2: fairness and back-to-back throughput
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, ALU_SUB, 32'(i), 32'(i), 5'd0);
    #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t2_grant%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      step();
      check($sformatf("t2_drop%0d", k), 32'(rsp_valid), 32'h0);
      step();
      check($sformatf("t2_valid%0d", k), 32'(rsp_valid), 32'h1);
      check($sformatf("t2_id%0d", k), 32'(rsp_id), 32'(k % 4));
      check($sformatf("t2_res%0d", k), rsp_result, 32'h0);
      check($sformatf("t2_zero%0d", k), 32'(rsp_zero), 32'h1);
    end
    req_valid = '0;
    step();

    // 3: backpressure (pointer now 1)
    rsp_ready = 1'b0;
    set_req(2, ALU_SLL, 32'd0, 32'd1, 5'd4);
    #1;
    check("t3_grant", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    set_req(0, ALU_AND, 32'hF0, 32'h3C, 5'd0);
    step();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t3_valid%0d", c), 32'(rsp_valid), 32'h1);
      check($sformatf("t3_res%0d", c), rsp_result, 32'd16);
      check($sformatf("t3_ready%0d", c), 32'(req_ready), 32'h0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("t3_b2b_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    check("t3_b2b_drop", 32'(rsp_valid), 32'h0);
    step();
    check("t3_b2b_res", rsp_result, 32'h30);
    check("t3_b2b_id", 32'(rsp_id), 32'h0);
    step();

    // 4: illegal ctl (pointer now 1)
    set_req(3, ALU_ILLEGAL, 32'hDEAD, 32'hBEEF, 5'd7);
    #1;
    check("t4_grant", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    check("t4_valid", 32'(rsp_valid), 32'h1);
    check("t4_err", 32'(rsp_err), 32'h1);
    check("t4_res", rsp_result, 32'h0);
    check("t4_zero", 32'(rsp_zero), 32'h0);
    check("t4_id", 32'(rsp_id), 32'h3);
    check("t4_alu_a", alu_a, 32'hF0);
    check("t4_alu_b", alu_b, 32'h3C);
    check("t4_alu_ctl", 32'(alu_ctl), 32'(ALU_AND));
    step();
    check("t4_retire", 32'(rsp_valid), 32'h0);

    // 6: wrap and idle pointer hold (pointer now 0)
    set_req(3, ALU_OR, 32'h1, 32'h2, 5'd0);
    #1;
    check("t6_grant3", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    step();
    check("t6_id3", 32'(rsp_id), 32'h3);
    check("t6_res3", rsp_result, 32'h3);
    step();
    for (int c = 0; c < 3; c++) begin
      check($sformatf("t6_idle%0d", c), 32'(req_ready), 32'h0);
      step();
    end
    set_req(0, ALU_ADD, 32'hFFFF_FFFF, 32'h1, 5'd0);
    set_req(2, ALU_AND, 32'h0, 32'h0, 5'd0);
    #1;
    check("t6_grant0", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    step();
    check("t6_res0", rsp_result, 32'h0);
    check("t6_zero0", 32'(rsp_zero), 32'h1);
    check("t6_err0", 32'(rsp_err), 32'h0);
    step();

    // 5: reset during ISSUE (pointer now 1)
    set_req(1, ALU_ADD, 32'h1, 32'h1, 5'd3);
    step();
    req_valid = '0;
    check("t5_issue_a", alu_a, 32'h1);
    reset = 1'b0;
    set_req(1, ALU_SUB, 32'd9, 32'd4, 5'd0);
    set_req(2, ALU_AND, 32'hF, 32'hF, 5'd0);
    step();
    check("t5_rsp_valid", 32'(rsp_valid), 32'h0);
    check("t5_alu_a", alu_a, 32'h0);
    check("t5_alu_shamt", 32'(alu_shamt), 32'h0);
    check("t5_rsp_result", rsp_result, 32'h0);
    check("t5_req_ready", 32'(req_ready), 32'h0);
    reset = 1'b1;
    #1;
    check("t5_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    step();
    check("t5_id", 32'(rsp_id), 32'h1);
    check("t5_res", rsp_result, 32'd5);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
